// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - shared types and constants for the JK counter family
package jk_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

  // {J,K} encodings applied to a single JK cell
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLEAR  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_RELOAD = 3'd2,
    OP_DEC    = 3'd3,
    OP_CLR    = 3'd4
  } op_t;

  function automatic logic [1:0] load_jk(input logic b);
    return b ? JK_SET : JK_CLEAR;
  endfunction

endpackage

// File: rtl/jk_down_counter_if.sv
// rtl/jk_down_counter_if.sv - host-side control/status bundle of jk_down_counter
interface jk_down_counter_if
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output start, stop, pause, load_val,
    input  count, busy, done, zero
  );

  modport slave (
    input  start, stop, pause, load_val,
    output count, busy, done, zero
  );

endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - negedge JK flip-flop with synchronous active-high reset
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(negedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  // Derived rather than stored so the pair can never disagree
  assign q_bar = ~q;

endmodule

// File: rtl/jk_down_counter.sv
// rtl/jk_down_counter.sv - loadable JK-cell down-counter; JK_DOWN_AUTO_RELOAD_EN enables auto-reload
module jk_down_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  jk_down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  op_t              op;
  logic             done_d;
  logic             done_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] borrow;
  logic             count_is_one;

  assign count_is_one = (q == ONE);

`ifdef JK_DOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      reload_q <= bus.load_val;
    end
  end
`endif

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op      = OP_HOLD;
    done_d  = 1'b0;
    if (rst) begin
      state_d = IDLE;
      op      = OP_CLR;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op = OP_LOAD;
            if (bus.load_val == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else if (bus.pause) begin
            op = OP_HOLD;
          end else if (count_is_one) begin
            done_d = 1'b1;
`ifdef JK_DOWN_AUTO_RELOAD_EN
            op     = OP_RELOAD;
`else
            op      = OP_DEC;
            state_d = DONE;
`endif
          end else begin
            op = OP_DEC;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bit i toggles on a decrement only when every lower bit is currently 0
  always_comb begin
    borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      borrow[i] = borrow[i-1] & q_bar[i-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] jk;

    always_comb begin
      jk = JK_HOLD;
      case (op)
        OP_LOAD:   jk = load_jk(bus.load_val[i]);
`ifdef JK_DOWN_AUTO_RELOAD_EN
        OP_RELOAD: jk = load_jk(reload_q[i]);
`endif
        OP_DEC:    jk = {borrow[i], borrow[i]};
        OP_CLR:    jk = JK_CLEAR;
        default:   jk = JK_HOLD;
      endcase
    end

    jk_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .j     (jk[1]),
      .k     (jk[0]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  assign bus.count = q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.zero  = &q_bar;

endmodule
